jtag_tap_slave: RTL
===================

JTAG_TAP_SLAVE -- requirements
Module: jtag_tap_slave

Interface
REQ-001 SHALL have parameter IR_W, default 4, instruction register width.
REQ-002 SHALL have parameter UDR_W, default 16, user data register width.
REQ-003 SHALL have parameter IDCODE, default 32'h1234_5679, 32-bit device ID captured by the IDCODE instruction.
REQ-004 SHALL have port TCK  in  1  sole clock; all state updates on its rising edge.
REQ-005 SHALL have port TRST_N  in  1  reset, synchronous and active-low.
REQ-006 SHALL have port TMS  in  1  TAP mode select, sampled on rising TCK.
REQ-007 SHALL have port TDI  in  1  serial data in, sampled on rising TCK.
REQ-008 SHALL have port TDO  out  1  serial data out.
REQ-009 SHALL have port TDO_EN  out  1  high when TDO is valid, i.e. state is SHIFT_IR or SHIFT_DR.
REQ-010 SHALL have port UDR_IN  in  UDR_W  parallel value loaded on CAPTURE_DR under USER.
REQ-011 SHALL have port UDR_OUT  out  UDR_W  user register, written on UPDATE_DR under USER.
REQ-012 SHALL have port UDR_UPD  out  1  one-cycle pulse when UDR_OUT changes.
REQ-013 SHALL have port IR_OUT  out  IR_W  current instruction.
REQ-014 SHALL have port STATE  out  4  current TAP state encoding.

Function
REQ-015 SHALL implement the 16-state IEEE 1149.1 TAP FSM, encoded TLR=0, IDLE=1, SEL_DR=2, CAP_DR=3, SH_DR=4, EX1_DR=5, PA_DR=6, EX2_DR=7, UPD_DR=8, SEL_IR=9, CAP_IR=10, SH_IR=11, EX1_IR=12, PA_IR=13, EX2_IR=14, UPD_IR=15.
REQ-016 SHALL use these transitions, written as TMS=0 / TMS=1:
- TLR -> IDLE / TLR
- IDLE -> IDLE / SEL_DR
- SEL_DR -> CAP_DR / SEL_IR
- SEL_IR -> CAP_IR / TLR
- CAP_x -> SH_x / EX1_x
- SH_x -> SH_x / EX1_x
- EX1_x -> PA_x / UPD_x
- PA_x -> PA_x / EX2_x
- EX2_x -> SH_x / UPD_x
- UPD_x -> IDLE / SEL_DR
REQ-017 SHALL decode instructions as IDCODE=4'h1, USER=4'h2, BYPASS=4'hF; every other code SHALL behave as BYPASS.
REQ-018 SHALL select the active data register from IR_OUT as IDCODE (32 bits), USER (UDR_W bits) or BYPASS (1 bit).
REQ-019 SHALL, at the posedge in CAP_IR, load the IR shift register with the constant {IR_W-2 zeros, 2'b01}.
REQ-020 SHALL, at the posedge in CAP_DR, load the selected DR shift register with IDCODE, UDR_IN, or 1'b0 respectively.
REQ-021 SHALL shift MSB-first: at each posedge in SH_x, shift the register left by one with TDI entering bit 0.
REQ-022 SHALL shift in SH_x regardless of TMS, so the bit presented with TMS=1 on exit is captured.
REQ-023 SHALL drive TDO combinationally from the MSB of the active shift register while TDO_EN=1, and 0 otherwise.
REQ-024 SHALL, at the posedge in UPD_IR, copy the IR shift register to IR_OUT.
REQ-025 SHALL, at the posedge in UPD_DR with IR_OUT=USER, copy the shift register to UDR_OUT and assert UDR_UPD for exactly the following cycle.
REQ-026 SHALL leave UDR_OUT unchanged in UPD_DR under IDCODE or BYPASS.
REQ-027 SHALL leave shift registers unchanged in PA_x and EX1_x/EX2_x, so shifting resumes where it left off after EX2_x -> SH_x.
REQ-028 SHALL load IR_OUT=IDCODE (4'h1) at any posedge while in TLR.
REQ-029 SHALL shift out IR-capture bits MSB-first; a shift longer than the register width SHALL emit the earlier TDI bits in order, and a shorter shift SHALL update with the partially shifted value.

Reset
REQ-030 SHALL, on any posedge with TRST_N=0, set STATE=TLR, IR_OUT=4'h1, UDR_OUT=0, UDR_UPD=0 and all shift registers to 0, overriding TMS.
REQ-031 SHALL, when reset is asserted mid-shift or mid-update, discard the in-flight data and leave UDR_OUT=0.
REQ-032 SHALL drive TDO=0 and TDO_EN=0 during and immediately after reset.

Verification
REQ-033 SHALL verify: TMS=1 for 5 cycles from every state -> STATE=0 (TLR).
REQ-034 SHALL verify: reset, then TMS 0,1,0,0, then 32 shift cycles -> TDO emits 0x12345679 MSB-first.
REQ-035 SHALL verify: load IR 4'h2, UDR_IN=16'hBEEF, DR scan shifting in 16'hA5C3 -> TDO emits 16'hBEEF, UDR_OUT=16'hA5C3, and UDR_UPD pulses once.
REQ-036 SHALL verify: IR=4'hF, shift 8 bits 8'b1011_0010 -> TDO emits 0 followed by the first 7 bits, delayed by one cycle.
REQ-037 SHALL verify: USER DR scan with 8 bits, PA_DR for 3 cycles, EX2 -> SH, then 8 more bits -> UDR_OUT equals all 16 bits in order.
REQ-038 SHALL verify: TRST_N=0 during SH_DR under USER with UDR_OUT=16'h1234 -> next cycle STATE=0, UDR_OUT=0, IR_OUT=4'h1, TDO_EN=0.

Source files
------------

// File: rtl/jtag_tap_slave.sv
// jtag_tap_slave: IEEE 1149.1 style TAP controller with an instruction
// register and three data registers (IDCODE, USER, BYPASS), all clocked
// by TCK with a synchronous active-low TRST_N.
module jtag_tap_slave #(
    parameter int          IR_W   = 4,
    parameter int          UDR_W  = 16,
    parameter logic [31:0] IDCODE = 32'h1234_5679
) (
    input  logic             TCK,
    input  logic             TRST_N,
    input  logic             TMS,
    input  logic             TDI,
    output logic             TDO,
    output logic             TDO_EN,
    input  logic [UDR_W-1:0] UDR_IN,
    output logic [UDR_W-1:0] UDR_OUT,
    output logic             UDR_UPD,
    output logic [IR_W-1:0]  IR_OUT,
    output logic [3:0]       STATE
);

    // Encoding is visible on STATE, so the values are fixed.
    typedef enum logic [3:0] {
        TLR    = 4'd0,
        IDLE   = 4'd1,
        SEL_DR = 4'd2,
        CAP_DR = 4'd3,
        SH_DR  = 4'd4,
        EX1_DR = 4'd5,
        PA_DR  = 4'd6,
        EX2_DR = 4'd7,
        UPD_DR = 4'd8,
        SEL_IR = 4'd9,
        CAP_IR = 4'd10,
        SH_IR  = 4'd11,
        EX1_IR = 4'd12,
        PA_IR  = 4'd13,
        EX2_IR = 4'd14,
        UPD_IR = 4'd15
    } tap_state_t;

    localparam logic [IR_W-1:0] INS_IDCODE = IR_W'(1);
    localparam logic [IR_W-1:0] INS_USER   = IR_W'(2);
    // Fixed pattern captured into the IR; the trailing 01 lets a host
    // detect the IR length on the chain.
    localparam logic [IR_W-1:0] IR_CAPTURE = {{(IR_W-2){1'b0}}, 2'b01};

    tap_state_t state;
    tap_state_t next_state;

    logic [IR_W-1:0]  ir_sr;
    logic [31:0]      id_sr;
    logic [UDR_W-1:0] udr_sr;
    logic             bypass_sr;

    logic sel_idcode;
    logic sel_user;

    // Data register selection; any unknown instruction falls back to BYPASS.
    assign sel_idcode = (IR_OUT == INS_IDCODE);
    assign sel_user   = (IR_OUT == INS_USER);

    assign STATE = state;

    // TAP state register; reset forces Test-Logic-Reset regardless of TMS.
    always_ff @(posedge TCK) begin
        if (!TRST_N) begin
            state <= TLR;
        end else begin
            state <= next_state;
        end
    end

    // TAP next-state decode driven by TMS.
    always_comb begin
        next_state = state;
        unique case (state)
            TLR:    next_state = TMS ? TLR    : IDLE;
            IDLE:   next_state = TMS ? SEL_DR : IDLE;
            SEL_DR: next_state = TMS ? SEL_IR : CAP_DR;
            CAP_DR: next_state = TMS ? EX1_DR : SH_DR;
            SH_DR:  next_state = TMS ? EX1_DR : SH_DR;
            EX1_DR: next_state = TMS ? UPD_DR : PA_DR;
            PA_DR:  next_state = TMS ? EX2_DR : PA_DR;
            EX2_DR: next_state = TMS ? UPD_DR : SH_DR;
            UPD_DR: next_state = TMS ? SEL_DR : IDLE;
            SEL_IR: next_state = TMS ? TLR    : CAP_IR;
            CAP_IR: next_state = TMS ? EX1_IR : SH_IR;
            SH_IR:  next_state = TMS ? EX1_IR : SH_IR;
            EX1_IR: next_state = TMS ? UPD_IR : PA_IR;
            PA_IR:  next_state = TMS ? EX2_IR : PA_IR;
            EX2_IR: next_state = TMS ? UPD_IR : SH_IR;
            UPD_IR: next_state = TMS ? SEL_DR : IDLE;
            default: next_state = TLR;
        endcase
    end

    // Instruction path: capture, shift (MSB out, TDI into bit 0), update.
    // TLR keeps reloading IDCODE so the device wakes up identifying itself.
    always_ff @(posedge TCK) begin
        if (!TRST_N) begin
            ir_sr  <= '0;
            IR_OUT <= INS_IDCODE;
        end else begin
            unique case (state)
                TLR:    IR_OUT <= INS_IDCODE;
                CAP_IR: ir_sr  <= IR_CAPTURE;
                SH_IR:  ir_sr  <= {ir_sr[IR_W-2:0], TDI};
                UPD_IR: IR_OUT <= ir_sr;
                default: ;
            endcase
        end
    end

    // Data shift registers: only the one selected by IR_OUT captures or
    // shifts; pause/exit states hold so a scan can resume where it stopped.
    always_ff @(posedge TCK) begin
        if (!TRST_N) begin
            id_sr     <= '0;
            udr_sr    <= '0;
            bypass_sr <= 1'b0;
        end else begin
            unique case (state)
                CAP_DR: begin
                    if (sel_idcode) begin
                        id_sr <= IDCODE;
                    end else if (sel_user) begin
                        udr_sr <= UDR_IN;
                    end else begin
                        bypass_sr <= 1'b0;
                    end
                end
                SH_DR: begin
                    if (sel_idcode) begin
                        id_sr <= {id_sr[30:0], TDI};
                    end else if (sel_user) begin
                        udr_sr <= {udr_sr[UDR_W-2:0], TDI};
                    end else begin
                        bypass_sr <= TDI;
                    end
                end
                default: ;
            endcase
        end
    end

    // User register update with a single-cycle strobe following the write.
    always_ff @(posedge TCK) begin
        if (!TRST_N) begin
            UDR_OUT <= '0;
            UDR_UPD <= 1'b0;
        end else begin
            UDR_UPD <= 1'b0;
            if ((state == UPD_DR) && sel_user) begin
                UDR_OUT <= udr_sr;
                UDR_UPD <= 1'b1;
            end
        end
    end

    // Serial output: MSB of the active shift register, only while shifting.
    always_comb begin
        TDO    = 1'b0;
        TDO_EN = 1'b0;
        unique case (state)
            SH_IR: begin
                TDO_EN = 1'b1;
                TDO    = ir_sr[IR_W-1];
            end
            SH_DR: begin
                TDO_EN = 1'b1;
                if (sel_idcode) begin
                    TDO = id_sr[31];
                end else if (sel_user) begin
                    TDO = udr_sr[UDR_W-1];
                end else begin
                    TDO = bypass_sr;
                end
            end
            default: ;
        endcase
    end

endmodule
